// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   PC_INIT_DEFAULT - reset fetch address (memory base address)
//   INSTR_NOP       - word presented to decode alongside a misalignment fault
//   fetch_state_t   - fetch control state {RUN, FAULT}
//   fetch_entry_t   - buffered instruction {pc, instr}
package fetch_pkg;

    localparam logic [31:0] PC_INIT_DEFAULT = 32'h0100_0000;
    localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bus bundle of the fetch stage.
//   imem_*     - instruction memory address / write strobe / combinational read data
//   redirect_* - single-cycle branch/jump redirect from execute
//   out_*      - valid/ready handshake towards decode
// Modports: master = fetch stage side, slave = environment (memory, execute, decode).
interface instr_fetch_if;

    logic [31:0] imem_address;
    logic        imem_read_write;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    modport master (
        output imem_address, imem_read_write,
        input  imem_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_instr, out_fault,
        input  out_ready
    );

    modport slave (
        input  imem_address, imem_read_write,
        output imem_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_instr, out_fault,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush.
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   push, pop    - write din / retire head; ignored when full / empty
//   flush        - discard all entries; takes priority over push and pop
//   din, dout    - write data, head data (read straight from storage)
//   count        - number of stored entries
//   full, empty  - occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem[rd_ptr_q];

    // A full FIFO never accepts a write, even alongside a pop: no pass-through.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; validity is tracked by count/pointers.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage between the PC and decode.
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   bus.imem_*   - byte address out (= fetch_pc), write strobe tied 0, read data in
//   bus.redirect_* - redirect request and target from execute
//   bus.out_*    - head entry {pc, instr, fault} to decode with valid/ready
// Parameters: PC_INIT (reset fetch address), FIFO_DEPTH (power of two, >= 2).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_INIT    = PC_INIT_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    instr_fetch_if.master bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    logic             push, pop, flush;
    fetch_entry_t     push_entry, head_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;

    assign bus.imem_address    = fetch_pc_q;
    assign bus.imem_read_write = 1'b0;
    assign push_entry          = '{pc: fetch_pc_q, instr: bus.imem_data};

    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W ($bits(fetch_entry_t))
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_entry),
        .dout  (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state: a redirect beats fetch and pop in the same cycle.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        if (bus.redirect_valid) begin
            flush = 1'b1;
            if (bus.redirect_pc[1:0] == 2'b00) begin
                state_d    = RUN;
                fetch_pc_d = bus.redirect_pc;
            end else begin
                state_d    = FAULT;
                fault_pc_d = bus.redirect_pc;
            end
        end else begin
            case (state_q)
                RUN: begin
                    push = !fifo_full;
                    pop  = (fifo_count != '0) && bus.out_ready;
                    if (!fifo_full) fetch_pc_d = fetch_pc_q + 32'd4;
                end
                FAULT: begin
                    // Parked until the next redirect; decode cannot drain a fault.
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Outputs: the fault entry overrides the FIFO head; an empty FIFO shows zeros.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_fault = 1'b0;
        bus.out_pc    = 32'h0;
        bus.out_instr = 32'h0;
        if (state_q == FAULT) begin
            bus.out_valid = 1'b1;
            bus.out_fault = 1'b1;
            bus.out_pc    = fault_pc_q;
            bus.out_instr = INSTR_NOP;
        end else begin
            bus.out_valid = (fifo_count != '0);
            if (!fifo_empty) begin
                bus.out_pc    = head_entry.pc;
                bus.out_instr = head_entry.instr;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= PC_INIT;
            fault_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized + directed bench for instr_fetch against a
// queue-based reference model of the fetch stage.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 2;

    logic clock;
    logic reset;
    instr_fetch_if bus();

    instr_fetch #(
        .PC_INIT    (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: returns 0 below the base, a scrambled address above.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < BASE) return 32'h0;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    always_comb bus.imem_data = mem_word(bus.imem_address);

    // Reference model state
    fetch_entry_t q[$];
    logic [31:0]  m_pc;
    logic [31:0]  m_fpc;
    bit           m_fault;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc    = BASE;
        m_fpc   = 32'h0;
        m_fault = 1'b0;
    endtask

    // One clock edge of the fetch stage, from the inputs seen before the edge.
    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        fetch_entry_t e;
        bit do_push;
        if (rv) begin
            q.delete();
            if (rpc[1:0] == 2'b00) begin
                m_fault = 1'b0;
                m_pc    = rpc;
            end else begin
                m_fault = 1'b1;
                m_fpc   = rpc;
            end
        end else if (!m_fault) begin
            do_push = (q.size() < DEPTH);
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (do_push) begin
                e.pc    = m_pc;
                e.instr = mem_word(m_pc);
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        logic        ev;
        logic [31:0] epc, einstr;
        ev     = m_fault ? 1'b1 : (q.size() != 0);
        epc    = m_fault ? m_fpc : (q.size() != 0 ? q[0].pc : 32'h0);
        einstr = m_fault ? INSTR_NOP : (q.size() != 0 ? q[0].instr : 32'h0);
        check_val("out_valid", 32'(bus.out_valid), 32'(ev));
        check_val("out_fault", 32'(bus.out_fault), 32'(m_fault));
        check_val("out_pc", bus.out_pc, epc);
        check_val("out_instr", bus.out_instr, einstr);
        check_val("imem_address", bus.imem_address, m_pc);
        check_val("imem_read_write", 32'(bus.imem_read_write), 32'h0);
    endtask

    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        @(posedge clock);
        model_step(rv, rpc, rdy);
        #1;
        compare_all();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        reset = 1'b0;

        // Reset and stream
        repeat (6) cycle(1'b0, 32'h0, 1'b1);

        // Backpressure, then resume
        repeat (5) cycle(1'b0, 32'h0, 1'b0);
        repeat (4) cycle(1'b0, 32'h0, 1'b1);

        // Redirect with a full FIFO and decode ready
        repeat (3) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0100_0100, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1);

        // Misaligned redirect, persistence, recovery
        cycle(1'b1, 32'h0100_0102, 1'b1);
        repeat (2) cycle(1'b0, 32'h0, 1'b1);
        repeat (2) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, BASE, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1);

        // Wrap-around of PC arithmetic
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1);

        // Asynchronous reset mid-stream with a full FIFO
        cycle(1'b1, BASE + 32'h40, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #1;
        compare_all();
        reset = 1'b0;
        repeat (3) cycle(1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic        rv;
            logic [31:0] rpc;
            logic        rdy;
            rv  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       rpc = BASE + 32'($urandom_range(0, 63)) * 32'd4;
                1:       rpc = BASE + 32'($urandom_range(0, 255));
                2:       rpc = 32'hFFFF_FFF8;
                default: rpc = $urandom();
            endcase
            cycle(rv, rpc, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
